// File: rtl/maxpool2x2.sv
// 2x2 / stride-2 max pooling over a channel-major, row-major feature map.
// Reads the four window elements one at a time from a synchronous-read BRAM,
// keeps a running signed maximum, then writes one pooled value per window.
//
// Read handshake: in_r_en is high for exactly the ISSUE cycle with in_r_addr
// valid; the BRAM returns in_r_q one cycle later and holds it, so the value is
// stable by CAPTURE. Write handshake: out_w_en/out_w_we are high for exactly
// the WRITE cycle, qualifying out_w_addr and out_w_d in that same cycle.
module maxpool2x2 #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_SIZE    = 28,
    localparam int OUT_SIZE  = IN_SIZE / 2,
    localparam int N_IN      = CHANNELS * IN_SIZE * IN_SIZE,
    localparam int N_OUT     = CHANNELS * OUT_SIZE * OUT_SIZE,
    localparam int IN_AW     = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int OUT_AW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [IN_AW-1:0]             in_r_addr,
    output logic                         in_r_en,
    input  logic signed [DATA_WIDTH-1:0] in_r_q,
    output logic [OUT_AW-1:0]            out_w_addr,
    output logic                         out_w_en,
    output logic                         out_w_we,
    output logic signed [DATA_WIDTH-1:0] out_w_d,
    output logic                         busy,
    done
);

    localparam int C_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int O_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    // An odd or too-small map has no clean 2x2 tiling; refuse to elaborate.
    generate
        if (IN_SIZE < 2 || (IN_SIZE % 2) != 0) begin : g_bad_in_size
            $error("maxpool2x2: IN_SIZE must be even and >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT1, WAIT2, CAPTURE, WRITE, FINISH
    } state_t;

    state_t                        state;
    logic [C_W-1:0]                c;
    logic [O_W-1:0]                oy, ox;
    logic [1:0]                    k;
    logic signed [DATA_WIDTH-1:0]  max_reg;

    logic signed [DATA_WIDTH-1:0]  cap_max;
    logic                          last_x, last_y, last_win;
    logic [C_W-1:0]                c_nxt;
    logic [O_W-1:0]                oy_nxt, ox_nxt;

    // Input index of window element kk: row 2*yy+kk[1], column 2*xx+kk[0].
    function automatic logic [IN_AW-1:0] in_index(
        input logic [C_W-1:0] cc, input logic [O_W-1:0] yy,
        input logic [O_W-1:0] xx, input logic [1:0] kk);
        return IN_AW'(cc) * IN_AW'(IN_SIZE * IN_SIZE)
             + IN_AW'({yy, kk[1]}) * IN_AW'(IN_SIZE)
             + IN_AW'({xx, kk[0]});
    endfunction

    function automatic logic [OUT_AW-1:0] out_index(
        input logic [C_W-1:0] cc, input logic [O_W-1:0] yy,
        input logic [O_W-1:0] xx);
        return OUT_AW'(cc) * OUT_AW'(OUT_SIZE * OUT_SIZE)
             + OUT_AW'(yy) * OUT_AW'(OUT_SIZE)
             + OUT_AW'(xx);
    endfunction

    assign busy = (state != IDLE);

    // Running max for the element arriving now, and the next window position.
    always_comb begin
        cap_max = max_reg;
        if (k == 2'd0 || in_r_q > max_reg) begin
            cap_max = in_r_q;
        end
        last_x   = (ox == O_W'(OUT_SIZE - 1));
        last_y   = (oy == O_W'(OUT_SIZE - 1));
        last_win = (out_index(c, oy, ox) == OUT_AW'(N_OUT - 1));
        c_nxt    = c;
        oy_nxt   = oy;
        ox_nxt   = ox;
        if (last_win) begin
            c_nxt  = '0;
            oy_nxt = '0;
            ox_nxt = '0;
        end else if (!last_x) begin
            ox_nxt = ox + 1'b1;
        end else begin
            ox_nxt = '0;
            if (!last_y) begin
                oy_nxt = oy + 1'b1;
            end else begin
                oy_nxt = '0;
                c_nxt  = c + 1'b1;
            end
        end
    end

    // Main FSM: walks windows, issues four reads each, writes the max.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            c          <= '0;
            oy         <= '0;
            ox         <= '0;
            k          <= '0;
            max_reg    <= '0;
            in_r_addr  <= '0;
            in_r_en    <= 1'b0;
            out_w_addr <= '0;
            out_w_en   <= 1'b0;
            out_w_we   <= 1'b0;
            out_w_d    <= '0;
            done       <= 1'b0;
        end else begin
            in_r_en  <= 1'b0;
            out_w_en <= 1'b0;
            out_w_we <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        c         <= '0;
                        oy        <= '0;
                        ox        <= '0;
                        k         <= '0;
                        in_r_en   <= 1'b1;
                        in_r_addr <= in_index('0, '0, '0, 2'd0);
                        state     <= ISSUE;
                    end
                end
                ISSUE:   state <= WAIT1;
                WAIT1:   state <= WAIT2;
                WAIT2:   state <= CAPTURE;
                CAPTURE: begin
                    max_reg <= cap_max;
                    if (k != 2'd3) begin
                        k         <= k + 2'd1;
                        in_r_en   <= 1'b1;
                        in_r_addr <= in_index(c, oy, ox, k + 2'd1);
                        state     <= ISSUE;
                    end else begin
                        out_w_en   <= 1'b1;
                        out_w_we   <= 1'b1;
                        out_w_addr <= out_index(c, oy, ox);
                        out_w_d    <= cap_max;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    c  <= c_nxt;
                    oy <= oy_nxt;
                    ox <= ox_nxt;
                    k  <= '0;
                    if (last_win) begin
                        state <= FINISH;
                    end else begin
                        in_r_en   <= 1'b1;
                        in_r_addr <= in_index(c_nxt, oy_nxt, ox_nxt, 2'd0);
                        state     <= ISSUE;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
